// File: rtl/serial_link_physical_rx_oversampled.sv
// Oversampled DDR receive channel for the serial link PHY.
// The forwarded clock and the data lanes are sampled with clk_i only. Each
// forwarded-clock edge restarts a phase counter. The lanes are captured when
// the counter reaches sample_shift_i. A fall/rise pair forms one
// 2*NumLanes-bit word, which is queued in a small FIFO.
//
// Ports:
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   enable_i             receiver enable; low returns the FSM to IDLE
//   sample_shift_i       clk_i cycles from edge detection to the sample point
//   ddr_rcv_clk_i        forwarded clock (idles high)
//   ddr_i                DDR data lanes
//   data_in_o            FIFO head word {rise_sample, fall_sample}
//   data_in_valid_o      FIFO not empty
//   data_in_ready_i      consumer pop
//   overflow_o           sticky: a word was dropped on a full FIFO
//   phase_err_o          sticky: an edge arrived before the pending sample
//   clear_err_i          clears both sticky flags
module serial_link_physical_rx_oversampled #(
  parameter int unsigned NumLanes   = 8,
  parameter int unsigned MaxClkDiv  = 32,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic [$clog2(MaxClkDiv):0]  sample_shift_i,
  input  logic                        ddr_rcv_clk_i,
  input  logic [NumLanes-1:0]         ddr_i,
  output logic [2*NumLanes-1:0]       data_in_o,
  output logic                        data_in_valid_o,
  input  logic                        data_in_ready_i,
  output logic                        overflow_o,
  output logic                        phase_err_o,
  input  logic                        clear_err_i
);

  localparam int unsigned PhaseW = $clog2(MaxClkDiv) + 1;
  localparam int unsigned WordW  = 2 * NumLanes;
  localparam int unsigned AddrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned PtrW   = AddrW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAMPLE_LO = 3'd1,
    WAIT_RISE = 3'd2,
    SAMPLE_HI = 3'd3,
    WAIT_FALL = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizers: clock lane idles high, data lanes reset low
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0]               clk_sync_q;
  logic [SyncStages-1:0][NumLanes-1:0] data_sync_q;
  logic                                sclk;
  logic [NumLanes-1:0]                 sdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '0;
    end else begin
      clk_sync_q[0]  <= ddr_rcv_clk_i;
      data_sync_q[0] <= ddr_i;
      for (int unsigned i = 1; i < SyncStages; i++) begin
        clk_sync_q[i]  <= clk_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign sclk  = clk_sync_q[SyncStages-1];
  assign sdata = data_sync_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Edge detection. The edge flags and the data are registered together, so
  // in the edge-detect cycle dat_q still holds the lanes as they were at the
  // forwarded-clock edge.
  // ---------------------------------------------------------------------------
  logic                pclk_q;
  logic                rise_q;
  logic                fall_q;
  logic [NumLanes-1:0] dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pclk_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      pclk_q <= sclk;
      rise_q <= ~pclk_q & sclk;
      fall_q <= pclk_q & ~sclk;
      dat_q  <= sdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter. An edge cycle counts as phase 0, and the counter saturates.
  // ---------------------------------------------------------------------------
  logic              edge_det;
  logic [PhaseW-1:0] phase_q;
  logic [PhaseW-1:0] phase_now;
  logic              at_sample;

  assign edge_det  = rise_q | fall_q;
  assign phase_now = edge_det ? '0 : phase_q;
  assign at_sample = (phase_now == sample_shift_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else if (edge_det) begin
      phase_q <= PhaseW'(1);
    end else if (phase_q != '1) begin
      phase_q <= phase_q + PhaseW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [NumLanes-1:0] lo_q, lo_d;
  logic                push;
  logic                perr_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

  // Next state; an opposite edge during SAMPLE_* forces the sample right away
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    push     = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE, WAIT_FALL: begin
        if (fall_q) begin
          if (at_sample) begin
            lo_d    = dat_q;
            state_d = WAIT_RISE;
          end else begin
            state_d = SAMPLE_LO;
          end
        end
      end
      SAMPLE_LO: begin
        if (rise_q) begin
          lo_d     = dat_q;
          perr_set = 1'b1;
          state_d  = SAMPLE_HI;
        end else if (at_sample) begin
          lo_d    = dat_q;
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise_q) begin
          if (at_sample) begin
            push    = 1'b1;
            state_d = WAIT_FALL;
          end else begin
            state_d = SAMPLE_HI;
          end
        end
      end
      SAMPLE_HI: begin
        if (fall_q) begin
          push     = 1'b1;
          perr_set = 1'b1;
          state_d  = SAMPLE_LO;
        end else if (at_sample) begin
          push    = 1'b1;
          state_d = WAIT_FALL;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable drops any half-received word but leaves the FIFO alone
    if (!enable_i) begin
      state_d  = IDLE;
      lo_d     = '0;
      push     = 1'b0;
      perr_set = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (pointers carry one extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [FifoDepth-1:0][WordW-1:0] mem_q;
  logic [PtrW-1:0]                 wr_ptr_q;
  logic [PtrW-1:0]                 rd_ptr_q;
  logic                            empty;
  logic                            full;
  logic                            pop;
  logic                            push_ok;
  logic                            ovf_set;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop     = ~empty & data_in_ready_i;
  // A pop in the same cycle frees the slot the push needs
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= {dat_q, lo_q};
        wr_ptr_q                   <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign data_in_o       = mem_q[rd_ptr_q[AddrW-1:0]];
  assign data_in_valid_o = ~empty;

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new event beats a simultaneous clear
  // ---------------------------------------------------------------------------
  logic overflow_q;
  logic phase_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_set  | (overflow_q  & ~clear_err_i);
      phase_err_q <= perr_set | (phase_err_q & ~clear_err_i);
    end
  end

  assign overflow_o  = overflow_q;
  assign phase_err_o = phase_err_q;

endmodule

// File: tb/tb_serial_link_physical_rx_oversampled.sv
// Self-checking bench for serial_link_physical_rx_oversampled.
// The forwarded clock and the data change together, once per half period.
// Inputs change 1 ns after the rising edge of clk_i. Outputs are observed on
// the falling edge of clk_i.
module tb_serial_link_physical_rx_oversampled;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable;
  logic [5:0]  shift;
  logic        ddr_clk;
  logic [7:0]  ddr;
  logic [15:0] data_out;
  logic        valid;
  logic        ready;
  logic        overflow;
  logic        perr;
  logic        clear;

  serial_link_physical_rx_oversampled dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable),
    .sample_shift_i (shift),
    .ddr_rcv_clk_i  (ddr_clk),
    .ddr_i          (ddr),
    .data_in_o      (data_out),
    .data_in_valid_o(valid),
    .data_in_ready_i(ready),
    .overflow_o     (overflow),
    .phase_err_o    (perr),
    .clear_err_i    (clear)
  );

  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_pass  = 0;
  logic        rnd_ready = 1'b0;

  // Every word the consumer pops, in order
  logic [15:0] rx_mem [0:511];
  int          rx_cnt = 0;

  always @(negedge clk_i) begin
    if (rst_ni && valid && ready) begin
      rx_mem[rx_cnt] <= data_out;
      rx_cnt         <= rx_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One word: low byte with the falling edge, high byte with the rising edge
  task automatic send_word(input logic [15:0] w, input int half);
    ddr_clk = 1'b0;
    ddr     = w[7:0];
    step(half);
    ddr_clk = 1'b1;
    ddr     = w[15:8];
    step(half);
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int k = 0;
    while (rx_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(rx_cnt), 32'(target));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    int          half;
    int          sh;
    logic [15:0] exp_word;
    logic        exp_perr;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] exp_q [$];
  logic        vhist [8];
  logic [15:0] dhist [8];
  logic [15:0] words [6];
  int          base;

  initial begin
    // A word whose edges arrive before the sample point becomes {hi, hi}
    vecs[0] = '{16'hA55A, 4,  2,  16'hA55A, 1'b0};
    vecs[1] = '{16'h00FF, 4,  0,  16'h00FF, 1'b0};
    vecs[2] = '{16'hFF00, 4,  3,  16'hFF00, 1'b0};
    vecs[3] = '{16'h1234, 2,  1,  16'h1234, 1'b0};
    vecs[4] = '{16'h8001, 2,  2,  16'h8080, 1'b1};
    vecs[5] = '{16'h3C5A, 2,  5,  16'h3C3C, 1'b1};
    vecs[6] = '{16'hFFFF, 16, 15, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h5AA5, 16, 31, 16'h5A5A, 1'b1};

    rst_ni = 1'b0; enable = 1'b0; shift = 6'd2; ddr_clk = 1'b1; ddr = 8'h00;
    ready = 1'b0; clear = 1'b0;
    step(3);
    @(negedge clk_i);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_perr", 32'(perr), 32'd0);
    rst_ni = 1'b1;
    enable = 1'b1;
    step(4);

    // Basic receive with latency measured from the rising edge at the pin
    ready = 1'b1;
    base  = rx_cnt;
    ddr_clk = 1'b0; ddr = 8'h5A;
    step(4);
    ddr_clk = 1'b1; ddr = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      vhist[k] = valid;
      dhist[k] = data_out;
    end
    check("latency_valid_c5", 32'(vhist[5]), 32'd0);
    check("latency_valid_c6", 32'(vhist[6]), 32'd1);
    check("latency_valid_c7", 32'(vhist[7]), 32'd0);
    check("latency_data_c6", 32'(dhist[6]), 32'hA55A);
    step(4);
    check("basic_count", 32'(rx_cnt), 32'(base + 1));
    check("basic_overflow", 32'(overflow), 32'd0);
    check("basic_perr", 32'(perr), 32'd0);

    // Table of single words over divider / sample-point corners
    for (int i = 0; i < 8; i++) begin
      pulse_clear();
      shift = 6'(vecs[i].sh);
      step(2);
      base = rx_cnt;
      send_word(vecs[i].word, vecs[i].half);
      wait_rx(base + 1, 80, $sformatf("vec%0d_count", i));
      check($sformatf("vec%0d_data", i), 32'(rx_mem[base]), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_perr", i), 32'(perr), 32'(vecs[i].exp_perr));
      step(5);
    end

    // Back-to-back stream
    pulse_clear();
    shift = 6'd2;
    base  = rx_cnt;
    for (int i = 1; i <= 16; i++) send_word(16'(i), 4);
    wait_rx(base + 16, 100, "stream_count");
    for (int i = 1; i <= 16; i++)
      check($sformatf("stream_w%0d", i), 32'(rx_mem[base+i-1]), 32'(i));
    check("stream_overflow", 32'(overflow), 32'd0);

    // Backpressure: ten words into an eight-entry FIFO
    ready = 1'b0;
    base  = rx_cnt;
    for (int i = 1; i <= 10; i++) send_word(16'h2000 + 16'(i), 4);
    step(10);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_no_pop", 32'(rx_cnt), 32'(base));
    ready = 1'b1;
    wait_rx(base + 8, 40, "bp_drain_count");
    step(10);
    check("bp_drain_exact", 32'(rx_cnt), 32'(base + 8));
    for (int i = 1; i <= 8; i++)
      check($sformatf("bp_w%0d", i), 32'(rx_mem[base+i-1]), 32'(16'h2000 + 16'(i)));
    pulse_clear();
    check("bp_clear", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the same cycle as the push
    ready = 1'b0;
    base  = rx_cnt;
    for (int i = 1; i <= 8; i++) send_word(16'h3000 + 16'(i), 4);
    step(6);
    check("full_valid", 32'(valid), 32'd1);
    check("full_no_overflow", 32'(overflow), 32'd0);
    ddr_clk = 1'b0; ddr = 8'h09;
    step(4);
    ddr_clk = 1'b1; ddr = 8'h30;
    step(5);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(6);
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_pop_count", 32'(rx_cnt), 32'(base + 1));
    check("simul_pop_word", 32'(rx_mem[base]), 32'h3001);
    ready = 1'b1;
    wait_rx(base + 9, 40, "simul_drain_count");
    for (int i = 2; i <= 9; i++)
      check($sformatf("simul_w%0d", i), 32'(rx_mem[base+i-1]), 32'(16'h3000 + 16'(i)));

    // Sample point later than the half period: every sample lands on the next edge
    pulse_clear();
    shift = 6'd5;
    base  = rx_cnt;
    for (int i = 0; i < 6; i++) begin
      words[i] = 16'h4100 + 16'(i * 16'h0111);
      send_word(words[i], 2);
    end
    wait_rx(base + 6, 40, "perr_count");
    step(5);
    check("perr_count_exact", 32'(rx_cnt), 32'(base + 6));
    check("perr_flag", 32'(perr), 32'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("perr_w%0d", i), 32'(rx_mem[base+i]),
            32'({words[i+1][7:0], words[i][15:8]}));
    check("perr_w5", 32'(rx_mem[base+5]), 32'({words[5][15:8], words[5][15:8]}));

    // Enable dropped after the low half of a word
    pulse_clear();
    shift = 6'd2;
    ready = 1'b0;
    base  = rx_cnt;
    send_word(16'h5101, 4);
    send_word(16'h5202, 4);
    send_word(16'h5303, 4);
    ddr_clk = 1'b0; ddr = 8'hEE;
    step(7);
    enable = 1'b0;
    step(2);
    check("en_fifo_kept", 32'(valid), 32'd1);
    ddr_clk = 1'b1; ddr = 8'h77;
    step(4);
    enable = 1'b1;
    step(3);
    send_word(16'hC3D2, 4);
    step(8);
    ready = 1'b1;
    wait_rx(base + 4, 40, "en_count");
    step(5);
    check("en_count_exact", 32'(rx_cnt), 32'(base + 4));
    check("en_w0", 32'(rx_mem[base]),   32'h5101);
    check("en_w1", 32'(rx_mem[base+1]), 32'h5202);
    check("en_w2", 32'(rx_mem[base+2]), 32'h5303);
    check("en_w3", 32'(rx_mem[base+3]), 32'hC3D2);

    // Reset in the middle of a burst with words queued and a flag set
    ready = 1'b0;
    shift = 6'd5;
    for (int i = 0; i < 3; i++) send_word(16'h6100 + 16'(i), 2);
    step(12);
    check("rst_pre_valid", 32'(valid), 32'd1);
    check("rst_pre_perr", 32'(perr), 32'd1);
    ddr_clk = 1'b0; ddr = 8'h11;
    step(3);
    rst_ni  = 1'b0;
    ddr_clk = 1'b1;
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    step(2);
    rst_ni = 1'b1;
    step(3);
    shift = 6'd2;
    ready = 1'b1;
    base  = rx_cnt;
    send_word(16'h6789, 4);
    send_word(16'h1357, 4);
    wait_rx(base + 2, 40, "rst_post_count");
    check("rst_post_w0", 32'(rx_mem[base]),   32'h6789);
    check("rst_post_w1", 32'(rx_mem[base+1]), 32'h1357);

    // Random bursts and random consumer backpressure against an in-order model
    pulse_clear();
    rnd_ready = 1'b1;
    base = rx_cnt;
    exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      int half;
      int nw;
      half  = int'($urandom_range(4, 8));
      shift = 6'($urandom_range(0, half - 1));
      nw    = int'($urandom_range(2, 8));
      for (int k = 0; k < nw; k++) begin
        logic [15:0] w;
        w = 16'($urandom);
        exp_q.push_back(w);
        send_word(w, half);
      end
      step(12);
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    wait_rx(base + exp_q.size(), 60, "rand_count");
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_w%0d", i), 32'(rx_mem[base+i]), 32'(exp_q[i]));
    check("rand_overflow", 32'(overflow), 32'd0);
    check("rand_perr", 32'(perr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
